seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, the number of multiplexed digit positions decoded (1..4).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, the consecutive stable clk cycles required before a capture (>=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port seg_in  input  7  active-low segment bus, bit order gfedcba; may be asynchronous to clk.
REQ-006 SHALL have port digit_in  input  4  active-low one-hot digit select; may be asynchronous to clk.
REQ-007 SHALL have port err_clr  input  1  synchronous clear of both sticky error flags.
REQ-008 SHALL have port code_out  output  4*NUM_DIGITS  decoded hex value per slot; slot i occupies bits [4i+3:4i].
REQ-009 SHALL have port blank_out  output  NUM_DIGITS  per-slot flag; 1 = last capture was all segments off.
REQ-010 SHALL have port frame_valid  output  1  one-cycle pulse when every slot has been captured since the previous pulse.
REQ-011 SHALL have port err_pattern  output  1  sticky flag: an undecodable segment pattern was captured.
REQ-012 SHALL have port err_select  output  1  sticky flag: an illegal digit select was stable for SETTLE_CYCLES.

Function
REQ-013 SHALL pass seg_in and digit_in through a two-flop synchronizer before any use; all later timing refers to synchronized values.
REQ-014 SHALL run FSM IDLE -> SETTLE -> CAPTURE -> WAIT.
- IDLE: synchronized digit_in == 4'b1111.
- SETTLE: digit_in != 4'b1111; a 0..SETTLE_CYCLES-1 counter runs.
- CAPTURE: exactly one cycle.
- WAIT: holds until the next input change.
REQ-015 SHALL reset the settle counter to 0 and re-enter SETTLE (or IDLE if digit_in == 4'b1111) on any change of synchronized seg_in or digit_in, in any state.
REQ-016 SHALL enter CAPTURE when the counter reaches SETTLE_CYCLES-1 with inputs unchanged.
REQ-017 SHALL treat a capture as legal when exactly one digit_in bit is 0 at index i < NUM_DIGITS.
REQ-018 SHALL treat any other non-4'b1111 select as illegal: set err_select and write no slot.
REQ-019 SHALL, on a legal capture, decode seg_in as follows:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
REQ-020 SHALL, for pattern 1111111, write slot code 0, set blank_out[i] and raise no error.
REQ-021 SHALL, for any other undecodable pattern, set err_pattern and leave slot i, blank_out[i] and the frame mask unchanged.
REQ-022 SHALL, on a decodable or blank capture, update slot i and set seen[i].
REQ-023 SHALL register code_out and blank_out so they change at the clock edge ending the CAPTURE cycle; capture latency is 2 + SETTLE_CYCLES + 1 edges after the input change is sampled.
REQ-024 SHALL, when seen becomes all-ones, pulse frame_valid high for exactly one cycle (registered, same edge as the slot update) and clear seen in that cycle.
REQ-025 SHALL count repeated captures of the same slot only once toward seen; the slot value is always overwritten.
REQ-026 SHALL let a new error in the same cycle as err_clr win, leaving its flag set.
REQ-027 SHALL not modify code_out, blank_out or seen on err_clr.

Reset
REQ-028 SHALL, on reset low, asynchronously drive:
- FSM to IDLE; counter, seen and synchronizers to reset values
- code_out = 0, blank_out = all-ones, frame_valid = 0, err_pattern = 0, err_select = 0
REQ-029 SHALL discard any partially settled capture when reset asserts mid-operation, and restart from IDLE after release.

Structure
REQ-030 SHALL place the FSM state enum, the sixteen segment pattern constants and SEG_BLANK (7'b1111111) in shared package seg_pkg.
REQ-031 SHALL implement the pattern-to-code lookup as combinational sub-module seg7_decode (in: seg[6:0]; out: code[3:0], blank, invalid).

Verification (NUM_DIGITS=3, SETTLE_CYCLES=4)
REQ-032 SHALL test the scan: digit_in 1110/1101/1011 with seg 0100100/1111000/0000110, each held 10 cycles -> code_out=12'hE72, blank_out=000, one frame_valid pulse.
REQ-033 SHALL test a glitch: seg_in changed after 3 stable cycles of a digit -> no capture until 4 further stable cycles; the final value is captured.
REQ-034 SHALL test bad inputs: digit_in=1100 held 10 cycles -> err_select=1, code_out unchanged; then seg 1010101 on digit 0 -> err_pattern=1, slot 0 unchanged.
REQ-035 SHALL test err_clr pulsed in the same cycle as a new illegal capture -> flag stays 1; a later lone err_clr -> flag 0.
REQ-036 SHALL test reset: reset low during SETTLE of slot 2 after slots 0 and 1 captured -> all outputs at reset values immediately; no frame_valid after release until three new captures.
REQ-037 SHALL test digit_in=0111 (index 3 >= NUM_DIGITS) stable -> err_select=1, no slot written.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan decoder.
//   scan_state_e : settle/capture FSM states
//   SEG_0..SEG_F : active-low gfedcba patterns for hex digits 0..F
//   SEG_BLANK    : all segments off
//   DIGIT_NONE   : active-low digit select with no digit driven
//   seg_pattern  : hex code -> segment pattern lookup
package seg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StWait
  } scan_state_e;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [3:0] DIGIT_NONE = 4'b1111;

  function automatic logic [6:0] seg_pattern(input logic [3:0] code);
    logic [6:0] pat;
    pat = SEG_BLANK;
    unique case (code)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      4'hF: pat = SEG_F;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex code lookup.
//   seg     : active-low segment pattern, gfedcba
//   code    : decoded hex value (0 for blank or undecodable)
//   blank   : pattern is all segments off
//   invalid : pattern is neither a hex digit nor blank
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       blank,
  output logic       invalid
);

  always_comb begin
    code    = 4'h0;
    blank   = (seg == SEG_BLANK);
    invalid = ~blank;
    for (int k = 0; k < 16; k++) begin
      if (seg == seg_pattern(4'(k))) begin
        code    = 4'(k);
        invalid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from a multiplexed seven-segment display bus.
//   clk, reset  : clock; asynchronous active-low reset
//   seg_in      : active-low segment bus (gfedcba), asynchronous to clk
//   digit_in    : active-low one-hot digit select, asynchronous to clk
//   err_clr     : synchronous clear of both sticky error flags
//   code_out    : decoded hex value per slot, slot i at [4i+3:4i]
//   blank_out   : per-slot flag, last capture was all segments off
//   frame_valid : one-cycle pulse once every slot has been captured
//   err_pattern : sticky, undecodable segment pattern captured
//   err_select  : sticky, illegal digit select held stable
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 3,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [3:0]              digit_in,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] code_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    frame_valid,
  output logic                    err_pattern,
  output logic                    err_select
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(SETTLE_CYCLES - 1);

  logic [6:0] seg_s1, seg_s2;
  logic [3:0] dig_s1, dig_s2;

  scan_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] code_q, code_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic fv_q, fv_d;
  logic ep_q, ep_d;
  logic es_q, es_d;

  logic                  change;
  logic [NUM_DIGITS-1:0] slot_mask;
  logic                  legal;
  logic [3:0]            dec_code;
  logic                  dec_blank;
  logic                  dec_invalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_s1 <= SEG_BLANK;
      seg_s2 <= SEG_BLANK;
      dig_s1 <= DIGIT_NONE;
      dig_s2 <= DIGIT_NONE;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= digit_in;
      dig_s2 <= dig_s1;
    end
  end

  // s2 is the value the FSM works on; s1 differing means s2 changes at the next edge,
  // so the counter restarts on the same edge that the new value appears.
  assign change = (seg_s1 != seg_s2) || (dig_s1 != dig_s2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (change) begin
      cnt_d   = '0;
      state_d = (dig_s1 == DIGIT_NONE) ? StIdle : StSettle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StSettle: begin
          if (cnt_q == CntMax) begin
            state_d = StCapture;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StCapture: state_d = StWait;
        StWait:    state_d = StWait;
        default:   state_d = StIdle;
      endcase
    end
  end

  // A legal select has exactly one low bit, at a slot index we implement.
  always_comb begin
    slot_mask = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_s2 == ~(4'b0001 << i)) begin
        slot_mask[i] = 1'b1;
      end
    end
  end

  assign legal = |slot_mask;

  seg7_decode u_decode (
    .seg     (seg_s2),
    .code    (dec_code),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  always_comb begin
    code_d  = code_q;
    blank_d = blank_q;
    seen_d  = seen_q;
    fv_d    = 1'b0;
    // Clear first so a new error in the same cycle overrides it.
    ep_d    = ep_q & ~err_clr;
    es_d    = es_q & ~err_clr;
    if (state_q == StCapture) begin
      if (!legal) begin
        es_d = 1'b1;
      end else if (dec_invalid) begin
        ep_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (slot_mask[i]) begin
            code_d[4*i +: 4] = dec_code;
            blank_d[i]       = dec_blank;
          end
        end
        if (&(seen_q | slot_mask)) begin
          fv_d   = 1'b1;
          seen_d = '0;
        end else begin
          seen_d = seen_q | slot_mask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      seen_q  <= '0;
      code_q  <= '0;
      blank_q <= '1;
      fv_q    <= 1'b0;
      ep_q    <= 1'b0;
      es_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      code_q  <= code_d;
      blank_q <= blank_d;
      fv_q    <= fv_d;
      ep_q    <= ep_d;
      es_q    <= es_d;
    end
  end

  assign code_out    = code_q;
  assign blank_out   = blank_q;
  assign frame_valid = fv_q;
  assign err_pattern = ep_q;
  assign err_select  = es_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (NUM_DIGITS=3, SETTLE_CYCLES=4) with an
// expected-state scoreboard and a frame_valid pulse counter.
module tb_seg_scan_decoder;

  localparam int unsigned ND = 3;
  localparam int unsigned SC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_in = 7'b1111111;
  logic [3:0]  digit_in = 4'b1111;
  logic        err_clr = 1'b0;
  logic [11:0] code_out;
  logic [2:0]  blank_out;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_select;

  int total = 0;
  int bad = 0;
  int fv_count = 0;
  int lat;

  typedef struct {
    string      tag;
    logic [11:0] code;
    logic [2:0]  blank;
    logic        ep;
    logic        es;
  } exp_t;

  exp_t sb[$];

  seg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .digit_in    (digit_in),
    .err_clr     (err_clr),
    .code_out    (code_out),
    .blank_out   (blank_out),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_select  (err_select)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && frame_valid) fv_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [11:0] c, input logic [2:0] b,
                      input logic ep, input logic es);
    exp_t e;
    e.tag = tag; e.code = c; e.blank = b; e.ep = ep; e.es = es;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_code"}, 32'(code_out), 32'(e.code));
    chk({e.tag, "_blank"}, 32'(blank_out), 32'(e.blank));
    chk({e.tag, "_errpat"}, 32'(err_pattern), 32'(e.ep));
    chk({e.tag, "_errsel"}, 32'(err_select), 32'(e.es));
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [3:0] d, input logic [6:0] s, input int n);
    digit_in = d;
    seg_in   = s;
    wait_neg(n);
  endtask

  // Counts negedges until code_out departs from prev; bounded at 12 cycles.
  task automatic measure(input logic [11:0] prev, output int l);
    l = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (l == 0 && code_out !== prev) l = k;
    end
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    wait_neg(1);
    err_clr = 1'b0;
    wait_neg(2);
  endtask

  initial begin
    #3 reset = 1'b0;
    #1;
    chk("rst_code", 32'(code_out), 32'h000);
    chk("rst_blank", 32'(blank_out), 32'h7);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_errpat", 32'(err_pattern), 32'h0);
    chk("rst_errsel", 32'(err_select), 32'h0);
    wait_neg(3);
    reset = 1'b1;
    wait_neg(3);

    // Scan of three digits, with first-capture latency measured.
    digit_in = 4'b1110; seg_in = 7'b0100100;
    measure(12'h000, lat);
    chk("scan0_latency", 32'(lat), 32'd7);
    push("scan0", 12'h002, 3'b110, 1'b0, 1'b0); pop_check();
    apply(4'b1101, 7'b1111000, 10);
    push("scan1", 12'h072, 3'b100, 1'b0, 1'b0); pop_check();
    chk("scan1_nofv", 32'(fv_count), 32'd0);
    apply(4'b1011, 7'b0000110, 10);
    push("scan2", 12'hE72, 3'b000, 1'b0, 1'b0); pop_check();
    chk("scan_fv", 32'(fv_count), 32'd1);
    apply(4'b1111, 7'b1111111, 5);

    // Glitch: 'A' held briefly then replaced by 'b'; only 'b' may land.
    apply(4'b1110, 7'b0001000, 4);
    seg_in = 7'b0000011;
    measure(12'hE72, lat);
    chk("glitch_latency", 32'(lat), 32'd7);
    push("glitch", 12'hE7B, 3'b000, 1'b0, 1'b0); pop_check();
    chk("glitch_nofv", 32'(fv_count), 32'd1);
    apply(4'b1111, 7'b1111111, 5);

    // Two digits selected at once.
    apply(4'b1100, 7'b0000000, 10);
    push("badsel", 12'hE7B, 3'b000, 1'b0, 1'b1); pop_check();
    apply(4'b1111, 7'b1111111, 5);

    // Undecodable pattern on digit 0.
    apply(4'b1110, 7'b1010101, 10);
    push("badpat", 12'hE7B, 3'b000, 1'b1, 1'b1); pop_check();
    apply(4'b1111, 7'b1111111, 5);

    clr_pulse();
    push("clr1", 12'hE7B, 3'b000, 1'b0, 1'b0); pop_check();

    // err_clr coincides with the capture edge of an illegal select.
    digit_in = 4'b1010; seg_in = 7'b0000000;
    wait_neg(6);
    err_clr = 1'b1;
    wait_neg(1);
    err_clr = 1'b0;
    wait_neg(3);
    push("clr_same", 12'hE7B, 3'b000, 1'b0, 1'b1); pop_check();
    apply(4'b1111, 7'b1111111, 5);
    clr_pulse();
    push("clr2", 12'hE7B, 3'b000, 1'b0, 1'b0); pop_check();

    // Digit index beyond NUM_DIGITS.
    apply(4'b0111, 7'b1000000, 10);
    push("sel3", 12'hE7B, 3'b000, 1'b0, 1'b1); pop_check();
    chk("sel3_nofv", 32'(fv_count), 32'd1);

    // Reset during settle of slot 2 after slots 0 and 1 captured.
    apply(4'b1110, 7'b1111001, 10);
    push("pre0", 12'hE71, 3'b000, 1'b0, 1'b1); pop_check();
    apply(4'b1101, 7'b0110000, 10);
    push("pre1", 12'hE31, 3'b000, 1'b0, 1'b1); pop_check();
    chk("pre_nofv", 32'(fv_count), 32'd1);
    digit_in = 4'b1011; seg_in = 7'b0011001;
    wait_neg(4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_code", 32'(code_out), 32'h000);
    chk("mid_rst_blank", 32'(blank_out), 32'h7);
    chk("mid_rst_fv", 32'(frame_valid), 32'h0);
    chk("mid_rst_errpat", 32'(err_pattern), 32'h0);
    chk("mid_rst_errsel", 32'(err_select), 32'h0);
    digit_in = 4'b1111; seg_in = 7'b1111111;
    wait_neg(3);
    reset = 1'b1;
    wait_neg(3);

    // Fresh frame after reset: slot 2, then 0, then a blank on slot 1.
    apply(4'b1011, 7'b0011001, 10);
    push("post2", 12'h400, 3'b011, 1'b0, 1'b0); pop_check();
    apply(4'b1110, 7'b0000010, 10);
    push("post0", 12'h406, 3'b010, 1'b0, 1'b0); pop_check();
    chk("post_nofv", 32'(fv_count), 32'd1);
    apply(4'b1101, 7'b1111111, 10);
    push("post1", 12'h406, 3'b010, 1'b0, 1'b0); pop_check();
    chk("post_fv", 32'(fv_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
